ilv2_dlv2: RTL and testbench
============================

Name: ilv2_dlv2

Overview:
- 2-way temporal bit interleaver (ilv2 path) and matching deinterleaver (dlv2 path) in one block.
- Interleave path: odd-indexed bits are delayed one cycle relative to even-indexed bits, so adjacent bits on the line come from consecutive words. This spreads burst errors across two words before FEC decode.
- Deinterleave path: delays the even bits by one cycle to realign them.
- Cascading the two paths yields the original word with exactly one clock of latency.

Parameters:
- WIDTH, 16, data word width in bits. Must be even and >= 2; an odd or smaller value is an elaboration error.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ilv_din  input  WIDTH  interleaver input word.
- ilv_dout  output  WIDTH  interleaved line word.
- dlv_din  input  WIDTH  deinterleaver input (line) word.
- dlv_dout  output  WIDTH  recovered word.

Behaviour:
- Bit classes: even bits are indices 0,2,4,… (mask 0x5555 for WIDTH=16); odd bits are indices 1,3,5,… (mask 0xAAAA).
- Interleave path:
  - ilv_dout[even] = ilv_din[even], combinational, zero latency.
  - ilv_dout[odd] = ilv_q[odd], where ilv_q[odd] is ilv_din[odd] registered on each rising clk edge.
- Deinterleave path:
  - dlv_dout[odd] = dlv_din[odd], combinational.
  - dlv_dout[even] = dlv_q[even], where dlv_q[even] is dlv_din[even] registered on each rising clk edge.
- Round trip: with ilv_dout wired to dlv_din, every bit of dlv_dout equals ilv_din sampled at the previous rising edge. Uniform latency is 1 cycle for all bits.
- Registers: only WIDTH/2 flops per path. No enable; capture happens every cycle and there is no handshake or backpressure.
- Reset:
  - rst_n low asynchronously clears ilv_q and dlv_q to 0.
  - During reset, ilv_dout odd bits = 0, and dlv_dout even bits = 0.
  - The combinational bits still follow their inputs during reset.
- Reset release: first capture occurs on the first rising edge with rst_n high. Round-trip output is valid from the second edge after release.
- Mid-stream reset: in-flight delayed halves are lost and read as 0. No other state exists, so there is no recovery sequence.
- No X propagation from the flops after reset. With inputs held constant, outputs settle to the inputs within one edge.

Optional Feature:
- Macro ILV2_OUT_REG_EN.
  - When defined: ilv_dout and dlv_dout are each driven from an additional full-width output register, reset to 0 by rst_n. Per-path latency rises by one cycle (interleave: even 1 / odd 2; deinterleave: odd 1 / even 2). Round-trip latency becomes 3 cycles.
  - When undefined: behaviour is exactly as stated above; per-path outputs are partly combinational and round-trip latency is 1 cycle.

Test Plan:
- Reset: hold rst_n=0 with ilv_din=0xFFFF and dlv_din=0xFFFF → ilv_dout=0x5555 and dlv_dout=0xAAAA. Release reset and clock one edge → both outputs = 0xFFFF.
- Interleave skew: ilv_din=0x0000 for several cycles, then 0xFFFF → ilv_dout=0x5555 immediately, 0xFFFF after the next edge. Stepping back to 0x0000 gives 0xAAAA, then 0x0000.
- Deinterleave skew: dlv_din steps 0x0000→0xFFFF → dlv_dout=0xAAAA immediately, then 0xFFFF after the next edge.
- Round-trip counter: wire ilv_dout to dlv_din. Drive an incrementing 16-bit counter changing on falling edges. At each rising edge, dlv_dout must equal the counter value sampled at the previous rising edge, with zero mismatches over about 50 cycles including the 0xFFFF→0x0000 wrap.
- Mid-stream reset: while the counter runs, pulse rst_n low asynchronously between edges → delayed bits read 0 immediately. Round trip matches again from the second edge after release.
- With ILV2_OUT_REG_EN defined: repeat the counter test → dlv_dout equals the counter value from 3 rising edges earlier.

Source files
------------

// File: rtl/ilv2_dlv2_if.sv
// ilv2_dlv2_if: data bus shared by the interleave and deinterleave paths.
interface ilv2_dlv2_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] ilv_din;
  logic [WIDTH-1:0] ilv_dout;
  logic [WIDTH-1:0] dlv_din;
  logic [WIDTH-1:0] dlv_dout;
  modport master (output ilv_din, dlv_din, input ilv_dout, dlv_dout);
  modport slave (input ilv_din, dlv_din, output ilv_dout, dlv_dout);
endinterface

// File: rtl/ilv2_dlv2.sv
// ilv2_dlv2: 2-way temporal bit interleaver (odd bits delayed) and deinterleaver (even bits delayed).
// Optional ILV2_OUT_REG_EN adds a full-width output register on both paths.
module ilv2_dlv2 #(parameter int WIDTH = 16) (
  input logic clk,
  input logic rst_n,
  ilv2_dlv2_if.slave bus
);
  localparam int H = WIDTH / 2;
  if (WIDTH < 2 || WIDTH % 2 != 0) begin : g_width_chk
    $error("ilv2_dlv2: WIDTH must be even and >= 2");
  end
  logic [H-1:0] ilv_q, ilv_d, dlv_q, dlv_d;
  logic [WIDTH-1:0] ilv_o, dlv_o;
  // Only the delayed half of each path is stored.
  always_comb begin
    ilv_d = '0;
    dlv_d = '0;
    ilv_o = '0;
    dlv_o = '0;
    for (int i = 0; i < H; i++) begin
      ilv_d[i] = bus.ilv_din[2*i+1];
      dlv_d[i] = bus.dlv_din[2*i];
      ilv_o[2*i] = bus.ilv_din[2*i];
      ilv_o[2*i+1] = ilv_q[i];
      dlv_o[2*i] = dlv_q[i];
      dlv_o[2*i+1] = bus.dlv_din[2*i+1];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ilv_q <= '0;
      dlv_q <= '0;
    end else begin
      ilv_q <= ilv_d;
      dlv_q <= dlv_d;
    end
  end
`ifdef ILV2_OUT_REG_EN
  logic [WIDTH-1:0] ilv_out_q, dlv_out_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ilv_out_q <= '0;
      dlv_out_q <= '0;
    end else begin
      ilv_out_q <= ilv_o;
      dlv_out_q <= dlv_o;
    end
  end
  assign bus.ilv_dout = ilv_out_q;
  assign bus.dlv_dout = dlv_out_q;
`else
  assign bus.ilv_dout = ilv_o;
  assign bus.dlv_dout = dlv_o;
`endif
endmodule

// File: tb/tb_ilv2_dlv2.sv
// tb_ilv2_dlv2: directed checks of skew, reset behaviour and round-trip latency.
module tb_ilv2_dlv2;
`ifdef ILV2_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic loop = 1'b0;
  logic [15:0] dlv_drv = '0;
  logic [15:0] cnt, cur, h0, h1, h2;
  int checks = 0;
  int failures = 0;
  int n;
  ilv2_dlv2_if #(.WIDTH(16)) bus ();
  ilv2_dlv2 #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.dlv_din = loop ? bus.ilv_dout : dlv_drv;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.ilv_din = 16'hFFFF;
    dlv_drv = 16'hFFFF;
    #1;
`ifndef ILV2_OUT_REG_EN
    chk("rst_ilv", bus.ilv_dout, 16'h5555);
    chk("rst_dlv", bus.dlv_dout, 16'hAAAA);
    @(posedge clk); #1;
    chk("rst_ilv_edge", bus.ilv_dout, 16'h5555);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ilv", bus.ilv_dout, 16'hFFFF);
    chk("rel_dlv", bus.dlv_dout, 16'hFFFF);
    @(negedge clk); bus.ilv_din = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk); bus.ilv_din = 16'hFFFF; #1;
    chk("ilv_rise_now", bus.ilv_dout, 16'h5555);
    @(posedge clk); #1;
    chk("ilv_rise_edge", bus.ilv_dout, 16'hFFFF);
    @(negedge clk); bus.ilv_din = 16'h0000; #1;
    chk("ilv_fall_now", bus.ilv_dout, 16'hAAAA);
    @(posedge clk); #1;
    chk("ilv_fall_edge", bus.ilv_dout, 16'h0000);
    @(negedge clk); bus.ilv_din = 16'h1234; #1;
    chk("ilv_pat_now", bus.ilv_dout, 16'h1014);
    @(posedge clk); #1;
    chk("ilv_pat_edge", bus.ilv_dout, 16'h1234);
    @(negedge clk); dlv_drv = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk); dlv_drv = 16'hFFFF; #1;
    chk("dlv_rise_now", bus.dlv_dout, 16'hAAAA);
    @(posedge clk); #1;
    chk("dlv_rise_edge", bus.dlv_dout, 16'hFFFF);
    @(negedge clk); dlv_drv = 16'h0000; #1;
    chk("dlv_fall_now", bus.dlv_dout, 16'h5555);
    @(posedge clk); #1;
    chk("dlv_fall_edge", bus.dlv_dout, 16'h0000);
`else
    chk("rst_ilv", bus.ilv_dout, 16'h0000);
    chk("rst_dlv", bus.dlv_dout, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ilv", bus.ilv_dout, 16'h5555);
    chk("rel_dlv", bus.dlv_dout, 16'hAAAA);
`endif
    @(negedge clk); loop = 1'b1;
    cnt = 16'hFFE8;
    n = 0;
    h0 = '0; h1 = '0; h2 = '0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      bus.ilv_din = cnt;
      cur = cnt;
      cnt++;
      if (c == 35) begin
        #2 rst_n = 1'b0;
        #1;
`ifdef ILV2_OUT_REG_EN
        chk("mid_rst_ilv", bus.ilv_dout, 16'h0000);
`else
        chk("mid_rst_ilv", bus.ilv_dout, bus.ilv_din & 16'h5555);
`endif
        chk("mid_rst_dlv", bus.dlv_dout, 16'h0000);
        #1 rst_n = 1'b1;
        n = 0;
      end
      @(posedge clk);
      h2 = h1; h1 = h0; h0 = cur;
      n++;
      #1;
      if (n >= LAT) chk("round_trip", bus.dlv_dout, (LAT == 1) ? h0 : h2);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
